path_delay_meter: RTL and testbench

- Launch/capture controller for chained delay paths; drives the path input and times the arrival of the matching edge at the path output.
- Toggles the input, synchronises the asynchronous path output into the clock domain, counts clock cycles until the expected level arrives, and repeats over 2^RUNS_LOG2 launches.
- Reports the per-run count, the accumulated sum and the average.
- Sits between the chained delay instance and the readout/UART logic of the spy design.

---
 rtl/path_delay_meter_pkg.sv | 18 +
 rtl/path_delay_meter_sync2.sv | 34 +++
 rtl/path_delay_meter.sv | 191 +++++++++++++++++++
 tb/tb_path_delay_meter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_delay_meter_pkg.sv
// Shared types and default constants for the path delay meter.
// Imported by path_delay_meter and path_sync2.
package path_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LAUNCH,
    WAIT,
    DONE
  } state_e;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_RUNS_LOG2  = 3;
  localparam int DEF_TIMEOUT    = 1023;
  localparam int DEF_SETTLE_CYC = 8;

endpackage

// File: rtl/path_delay_meter_sync2.sv
// Two-flop synchronizer bringing the asynchronous path output into the clk domain.
// Both stages are kept and flagged ASYNC_REG so tools place them adjacently.
module path_sync2
  import path_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE", keep = "true" *) logic meta_q;
  (* ASYNC_REG = "TRUE", keep = "true" *) logic sync_q;
  logic meta_d;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/path_delay_meter.sv
// Launch/capture controller: toggles pathInput, times the matching edge on pathResult
// over 2^RUNS_LOG2 runs. Optional min/max tracking under macro PATH_DELAY_MINMAX_EN.
module path_delay_meter
  import path_meter_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RUNS_LOG2  = DEF_RUNS_LOG2,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter bit PATH_INV   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       pathInput,
  input  logic                       pathResult,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [CNT_W-1:0]           delayCycles,
  output logic [CNT_W+RUNS_LOG2-1:0] delaySum,
  output logic [CNT_W-1:0]           delayAvg
`ifdef PATH_DELAY_MINMAX_EN
  ,
  output logic [CNT_W-1:0]           minCycles,
  output logic [CNT_W-1:0]           maxCycles
`endif
);

  localparam int SUM_W = CNT_W + RUNS_LOG2;
  localparam int RUN_W = RUNS_LOG2 + 1;

  // The counter aborts on the edge where it would reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'((1 << RUNS_LOG2) - 1);
  localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(1);

  state_e             state_q, state_d;
  logic               path_in_q, path_in_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   avg_q, avg_d;
`ifdef PATH_DELAY_MINMAX_EN
  logic [CNT_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]   max_q, max_d;
`endif

  logic sync_res;
  logic exp_lvl;
  logic match;

  path_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pathResult),
    .q     (sync_res)
  );

  assign exp_lvl = path_in_q ^ PATH_INV;
  assign match   = (sync_res == exp_lvl);

  always_comb begin
    state_d   = state_q;
    path_in_d = path_in_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    timeout_d = timeout_q;
    cycles_d  = cycles_q;
    sum_d     = sum_q;
    avg_d     = avg_q;
`ifdef PATH_DELAY_MINMAX_EN
    min_d     = min_q;
    max_d     = max_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          timeout_d = 1'b0;
          sum_d     = '0;
          run_d     = '0;
          cnt_d     = '0;
`ifdef PATH_DELAY_MINMAX_EN
          min_d     = '1;
          max_d     = '0;
`endif
          state_d   = SETTLE;
        end
      end

      SETTLE: begin
        if ((cnt_q >= SETTLE_LAST) && match) begin
          state_d = LAUNCH;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = cnt_q + CNT_ONE;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      LAUNCH: begin
        path_in_d = ~path_in_q;
        cnt_d     = '0;
        state_d   = WAIT;
      end

      WAIT: begin
        if (match) begin
          cycles_d = cnt_q;
          sum_d    = sum_q + SUM_W'(cnt_q);
          run_d    = run_q + RUN_ONE;
          cnt_d    = '0;
`ifdef PATH_DELAY_MINMAX_EN
          if (cnt_q < min_q) min_d = cnt_q;
          if (cnt_q > max_q) max_d = cnt_q;
`endif
          state_d  = (run_q == RUN_LAST) ? DONE : SETTLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = cnt_q + CNT_ONE;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Average is refreshed on entry to DONE so it is valid alongside the done pulse.
    if ((state_q != DONE) && (state_d == DONE)) begin
      avg_d = CNT_W'(sum_d >> RUNS_LOG2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      path_in_q <= 1'b0;
      cnt_q     <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
      sum_q     <= '0;
      avg_q     <= '0;
`ifdef PATH_DELAY_MINMAX_EN
      min_q     <= '0;
      max_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      path_in_q <= path_in_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
      sum_q     <= sum_d;
      avg_q     <= avg_d;
`ifdef PATH_DELAY_MINMAX_EN
      min_q     <= min_d;
      max_q     <= max_d;
`endif
    end
  end

  assign pathInput   = path_in_q;
  assign busy        = (state_q == SETTLE) || (state_q == LAUNCH) || (state_q == WAIT);
  assign done        = (state_q == DONE);
  assign timeout     = timeout_q;
  assign delayCycles = cycles_q;
  assign delaySum    = sum_q;
  assign delayAvg    = avg_q;
`ifdef PATH_DELAY_MINMAX_EN
  assign minCycles   = min_q;
  assign maxCycles   = max_q;
`endif

endmodule

// File: tb/tb_path_delay_meter.sv
// Self-checking bench for path_delay_meter: register-delay path models, loopback,
// stuck path, start spam, mid-run reset; min/max checks under PATH_DELAY_MINMAX_EN.
module tb_path_delay_meter;
  import path_meter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic        pi0, pi1;
  logic        pr0, pr1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic        to0, to1;
  logic [15:0] cyc0, cyc1;
  logic [18:0] sum0, sum1;
  logic [15:0] avg0, avg1;
`ifdef PATH_DELAY_MINMAX_EN
  logic [15:0] min0, max0, min1, max1;
`endif

  int vectors = 0;
  int miscompares = 0;

  // 0: fixed 5-register delay, 1: 3/6 alternating by level, 2: stuck at 0
  int mode = 0;
  logic [7:0] sr0 = '0;

  typedef struct {
    int cycles;
    int sum;
    int avg;
    int to;
    int toggles;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) sr0 <= {sr0[6:0], pi0};

  always_comb begin
    case (mode)
      2:       pr0 = 1'b0;
      1:       pr0 = pi0 ? sr0[2] : sr0[5];
      default: pr0 = sr0[4];
    endcase
  end

  assign pr1 = ~pi1;

  path_delay_meter dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start0),
    .pathInput   (pi0),
    .pathResult  (pr0),
    .busy        (busy0),
    .done        (done0),
    .timeout     (to0),
    .delayCycles (cyc0),
    .delaySum    (sum0),
    .delayAvg    (avg0)
`ifdef PATH_DELAY_MINMAX_EN
    ,
    .minCycles   (min0),
    .maxCycles   (max0)
`endif
  );

  path_delay_meter #(.PATH_INV(1'b1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .pathInput   (pi1),
    .pathResult  (pr1),
    .busy        (busy1),
    .done        (done1),
    .timeout     (to1),
    .delayCycles (cyc1),
    .delaySum    (sum1),
    .delayAvg    (avg1)
`ifdef PATH_DELAY_MINMAX_EN
    ,
    .minCycles   (min1),
    .maxCycles   (max1)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_pi(input bit sel);
    return sel ? pi1 : pi0;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? done1 : done0;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy0;
  endfunction

  // Single-cycle start pulse driven from a negedge; busy must follow after one edge.
  task automatic apply_stimulus(input bit sel, input exp_t e);
    sb.push_back(e);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    check_output(sel ? "busy_after_start1" : "busy_after_start0", 32'(get_busy(sel)), 32'd1);
  endtask

  // Waits for done while counting launches; optionally spams start on dut0.
  task automatic wait_done(input bit sel, input int budget, input int spam,
                           output int toggles, output int elapsed, output bit seen);
    logic prev;
    int first;
    prev    = get_pi(sel);
    first   = -1;
    toggles = 0;
    elapsed = -1;
    seen    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (get_pi(sel) !== prev) begin
        toggles++;
        if (first < 0) first = i;
        prev = get_pi(sel);
      end
      if (get_done(sel)) begin
        seen    = 1'b1;
        elapsed = i - first;
        break;
      end
      start0 = (i < spam) && (i % 3 == 0);
    end
    start0 = 1'b0;
  endtask

  task automatic run_and_check(input bit sel, input string name, input int spam, output int elapsed);
    int toggles;
    bit seen;
    exp_t e;
    wait_done(sel, 3000, spam, toggles, elapsed, seen);
    check_output({name, "_done_seen"}, 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      check_output({name, "_scoreboard_entry"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_output({name, "_cycles"},  sel ? 32'(cyc1) : 32'(cyc0), 32'(e.cycles));
      check_output({name, "_sum"},     sel ? 32'(sum1) : 32'(sum0), 32'(e.sum));
      check_output({name, "_avg"},     sel ? 32'(avg1) : 32'(avg0), 32'(e.avg));
      check_output({name, "_timeout"}, sel ? 32'(to1)  : 32'(to0),  32'(e.to));
      check_output({name, "_toggles"}, 32'(toggles), 32'(e.toggles));
    end
    @(negedge clk);
    check_output({name, "_done_one_cycle"}, 32'(get_done(sel)), 32'd0);
    check_output({name, "_busy_dropped"},   32'(get_busy(sel)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int elapsed;
    int tg;
    logic prev;

    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_pathInput", 32'(pi0),   32'd0);
    check_output("rst_busy",      32'(busy0), 32'd0);
    check_output("rst_done",      32'(done0), 32'd0);
    check_output("rst_timeout",   32'(to0),   32'd0);
    check_output("rst_cycles",    32'(cyc0),  32'd0);
    check_output("rst_sum",       32'(sum0),  32'd0);
    check_output("rst_avg",       32'(avg0),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] fixed 5-register delay");
    mode = 0;
    apply_stimulus(1'b0, '{cycles: 7, sum: 56, avg: 7, to: 0, toggles: 8});
    run_and_check(1'b0, "d5", 0, elapsed);

    $display("[TB] inverting combinational loopback");
    apply_stimulus(1'b1, '{cycles: 2, sum: 16, avg: 2, to: 0, toggles: 8});
    run_and_check(1'b1, "loop", 0, elapsed);

    $display("[TB] stuck path timeout");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mode = 2;
    apply_stimulus(1'b0, '{cycles: 0, sum: 0, avg: 0, to: 1, toggles: 1});
    run_and_check(1'b0, "stuck", 0, elapsed);
    check_output("stuck_wait_cycles", 32'(elapsed), 32'd1023);
    check_output("stuck_timeout_sticky", 32'(to0), 32'd1);

    $display("[TB] start spam while busy");
    mode = 0;
    apply_stimulus(1'b0, '{cycles: 7, sum: 56, avg: 7, to: 0, toggles: 8});
    run_and_check(1'b0, "spam", 60, elapsed);
    repeat (20) @(negedge clk);
    check_output("spam_no_restart", 32'(busy0), 32'd0);

    $display("[TB] reset during third run");
    sb.push_back('{cycles: 0, sum: 0, avg: 0, to: 0, toggles: 0});
    void'(sb.pop_back());
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    prev = pi0;
    tg = 0;
    for (int i = 0; i < 500 && tg < 3; i++) begin
      @(negedge clk);
      if (pi0 !== prev) begin
        tg++;
        prev = pi0;
      end
    end
    check_output("midrst_reached_run3", 32'(tg), 32'd3);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_pathInput", 32'(pi0),   32'd0);
    check_output("midrst_busy",      32'(busy0), 32'd0);
    check_output("midrst_cycles",    32'(cyc0),  32'd0);
    check_output("midrst_sum",       32'(sum0),  32'd0);
    check_output("midrst_avg",       32'(avg0),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(1'b0, '{cycles: 7, sum: 56, avg: 7, to: 0, toggles: 8});
    run_and_check(1'b0, "after_rst", 0, elapsed);

    $display("[TB] alternating 3/6 register delay");
    mode = 1;
    apply_stimulus(1'b0, '{cycles: 8, sum: 52, avg: 6, to: 0, toggles: 8});
    run_and_check(1'b0, "alt", 0, elapsed);
`ifdef PATH_DELAY_MINMAX_EN
    check_output("alt_min", 32'(min0), 32'd5);
    check_output("alt_max", 32'(max0), 32'd8);
`endif

    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
